// File: rtl/mod_segment_player_pkg.sv
// Shared types and constants for the modulation segment player.
// mod_settings_t is the layout the controller register block hands over on its update strobe.
package mod_segment_player_pkg;

    localparam int IDX_W = 15;
    localparam int DIV_W = 32;
    localparam logic [31:0] REP_INFINITE = 32'hFFFF_FFFF;

    typedef struct packed {
        logic             req_rd_segment;
        logic [IDX_W-1:0] cycle_0;
        logic [DIV_W-1:0] freq_div_0;
        logic [IDX_W-1:0] cycle_1;
        logic [DIV_W-1:0] freq_div_1;
        logic [31:0]      rep;
    } mod_settings_t;

    typedef enum logic [1:0] {
        RUN,
        WAIT_SWAP,
        FINITE,
        STOPPED
    } mod_play_state_t;

endpackage

// File: rtl/mod_sample_divider.sv
// Divides the base-rate tick down to a sample strobe.
// The strobe is combinational in the tick cycle, so the player steps its index on that same edge.
module mod_sample_divider #(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clear,
    input  logic [DIV_W-1:0] freq_div,
    output logic             strobe
);

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] last;

    // A divide of 0 acts as 1; >= keeps the divider alive if the divide shrinks below the count.
    always_comb begin
        last   = (freq_div == '0) ? '0 : freq_div - DIV_W'(1);
        strobe = tick && (count >= last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= strobe ? '0 : count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/mod_segment_player.sv
// Turns latched modulation settings into a running sample index and active segment select,
// handling immediate and end-of-loop segment swaps and finite-repeat playback.
module mod_segment_player
    import mod_segment_player_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             update,
    input  mod_settings_t    settings,
    output logic             segment,
    output logic [IDX_W-1:0] idx,
    output logic             stop,
    output logic             swapped,
    output logic [31:0]      loop_cnt
);

    mod_play_state_t  state;
    mod_play_state_t  state_next;
    logic             pend;
    logic             pend_next;

    logic [IDX_W-1:0] cycle_0;
    logic [IDX_W-1:0] cycle_1;
    logic [DIV_W-1:0] div_0;
    logic [DIV_W-1:0] div_1;
    logic [31:0]      rep;

    logic [IDX_W-1:0] cycle_act;
    logic [DIV_W-1:0] div_act;
    logic             strobe;
    logic             wrap;
    logic             imm_swap;
    logic             fin_swap;
    logic             finish;
    logic             restart;
    logic             step;
    logic             seg_after;
    logic [31:0]      loop_sat;

    always_comb begin
        cycle_act = segment ? cycle_1 : cycle_0;
        div_act   = segment ? div_1 : div_0;
        wrap      = strobe && (idx >= cycle_act);
        loop_sat  = (loop_cnt == '1) ? loop_cnt : loop_cnt + 32'd1;
    end

    mod_sample_divider #(
        .DIV_W (DIV_W)
    ) u_divider (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .clear    (imm_swap || fin_swap),
        .freq_div (div_act),
        .strobe   (strobe)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            pend  <= 1'b0;
        end else begin
            state <= state_next;
            pend  <= pend_next;
        end
    end

    // An update is judged against the segment as it will be after any swap firing this cycle.
    always_comb begin
        state_next = state;
        pend_next  = pend;
        case (state)
            RUN:       if (imm_swap) pend_next = 1'b0;
            WAIT_SWAP: if (fin_swap) state_next = FINITE;
            FINITE:    if (finish)   state_next = STOPPED;
            default:   ;
        endcase
        if (update) begin
            if (settings.req_rd_segment != seg_after) begin
                if (settings.rep == REP_INFINITE) begin
                    state_next = RUN;
                    pend_next  = 1'b1;
                end else begin
                    state_next = WAIT_SWAP;
                    pend_next  = 1'b0;
                end
            end else begin
                pend_next = 1'b0;
                if (state_next == WAIT_SWAP) begin
                    state_next = RUN;
                end else if (settings.rep == REP_INFINITE &&
                             (state_next == FINITE || state == STOPPED)) begin
                    state_next = RUN;
                end
            end
        end
    end

    always_comb begin
        imm_swap  = (state == RUN) && pend && strobe;
        fin_swap  = (state == WAIT_SWAP) && wrap;
        finish    = (state == FINITE) && wrap &&
                    (({1'b0, loop_cnt} + 33'd1) == ({1'b0, rep} + 33'd1));
        restart   = (state == STOPPED) && update &&
                    (settings.req_rd_segment == segment) &&
                    (settings.rep == REP_INFINITE);
        step      = strobe && (state != STOPPED) && !imm_swap && !fin_swap && !finish;
        seg_after = segment ^ (imm_swap || fin_swap);
    end

    // Event decisions above use the old settings copy; the new copy lands on this same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            segment  <= 1'b0;
            idx      <= '0;
            stop     <= 1'b0;
            swapped  <= 1'b0;
            loop_cnt <= '0;
            cycle_0  <= '0;
            cycle_1  <= '0;
            div_0    <= DIV_W'(1);
            div_1    <= DIV_W'(1);
            rep      <= REP_INFINITE;
        end else begin
            swapped <= imm_swap || fin_swap;
            if (update) begin
                cycle_0 <= settings.cycle_0;
                cycle_1 <= settings.cycle_1;
                div_0   <= settings.freq_div_0;
                div_1   <= settings.freq_div_1;
                rep     <= settings.rep;
            end
            if (imm_swap || fin_swap) begin
                segment  <= ~segment;
                idx      <= '0;
                loop_cnt <= '0;
                stop     <= 1'b0;
            end else if (finish) begin
                idx      <= cycle_act;
                loop_cnt <= loop_sat;
                stop     <= 1'b1;
            end else if (restart) begin
                idx  <= '0;
                stop <= 1'b0;
            end else if (step) begin
                idx <= wrap ? '0 : idx + IDX_W'(1);
                if (state == FINITE && wrap) begin
                    loop_cnt <= loop_sat;
                end
            end
        end
    end

endmodule
